i8008_bus_ctrl: RTL

I8008_BUS_CTRL -- requirements
Module: i8008_bus_ctrl

---
 rtl/i8008_bus_ctrl_if.sv | 33 +++
 rtl/i8008_bus_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/i8008_bus_ctrl_if.sv
// Bus bundle between the 8008 T-state/data side, the memory port and the I/O port.
// The master side is the bus controller; the slave side is the CPU/memory/I/O environment.
interface i8008_bus_ctrl_if;
  logic [2:0]  state_in;
  logic [7:0]  d_from_cpu;
  logic [7:0]  d_to_cpu;
  logic        ready_to_cpu;
  logic [7:0]  int_vector;
  logic [13:0] mem_addr;
  logic        mem_req;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        io_strb;
  logic [4:0]  io_port;
  logic [7:0]  io_wdata;
  logic [7:0]  io_rdata;
  logic [1:0]  cyc_type;
  logic        bus_err;

  modport master (
    input  state_in, d_from_cpu, int_vector, mem_ack, mem_rdata, io_rdata,
    output d_to_cpu, ready_to_cpu, mem_addr, mem_req, mem_we, mem_wdata,
           io_strb, io_port, io_wdata, cyc_type, bus_err
  );

  modport slave (
    output state_in, d_from_cpu, int_vector, mem_ack, mem_rdata, io_rdata,
    input  d_to_cpu, ready_to_cpu, mem_addr, mem_req, mem_we, mem_wdata,
           io_strb, io_port, io_wdata, cyc_type, bus_err
  );
endinterface

// File: rtl/i8008_bus_ctrl.sv
// 8008 bus controller: decodes the CPU T-states, latches the address/cycle
// type, and runs memory reads/writes, I/O accesses and interrupt jams with
// a request timeout. A T2 that shows up while a write is still in flight is
// parked and replayed once the write finishes.
module i8008_bus_ctrl #(
  parameter int TIMEOUT = 15
) (
  input logic clk,
  input logic rst,
  i8008_bus_ctrl_if.master bus
);

  localparam logic [2:0] T_T1  = 3'd0;
  localparam logic [2:0] T_T1I = 3'd1;
  localparam logic [2:0] T_T2  = 3'd2;
  localparam logic [2:0] T_T3  = 3'd4;

  localparam logic [1:0] CYC_PCI = 2'b00;
  localparam logic [1:0] CYC_PCR = 2'b01;
  localparam logic [1:0] CYC_PCC = 2'b10;
  localparam logic [1:0] CYC_PCW = 2'b11;

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_HOLD,
    S_WR_DATA,
    S_WR_REQ,
    S_IO
  } state_t;

  state_t state_reg, state_next;

  logic [7:0]       addr_lo_reg;      // follows the bus on every T1/T1I
  logic [7:0]       addr_lo_lat_reg;  // low address frozen for the running cycle
  logic [5:0]       addr_hi_reg;
  logic [1:0]       cyc_type_reg;
  logic             int_pending_reg;
  logic [7:0]       d_to_cpu_reg;
  logic [7:0]       mem_wdata_reg;
  logic [CNT_W-1:0] tmo_cnt_reg;
  logic             bus_err_reg;
  logic             io_strb_reg;
  logic             seen_t3_reg;
  logic             pend_valid_reg;
  logic [7:0]       pend_data_reg;

  logic       t2_go;
  logic [7:0] t2_data;
  logic [1:0] t2_cyc;
  logic       req_state;
  logic       tmo_hit;
  logic       req_done;
  logic       io_inp;
  logic       mem_req;
  logic       mem_we;
  logic       ready;
  logic [4:0] io_port_w;

  // A parked T2 (captured during a write) takes precedence over the live bus.
  assign t2_go     = pend_valid_reg || (bus.state_in == T_T2);
  assign t2_data   = pend_valid_reg ? pend_data_reg : bus.d_from_cpu;
  assign t2_cyc    = t2_data[7:6];
  assign req_state = (state_reg == S_RD_REQ) || (state_reg == S_WR_REQ);
  // An ack on the last allowed cycle still wins over the timeout.
  assign tmo_hit   = req_state && !bus.mem_ack && (tmo_cnt_reg == CNT_LAST);
  assign req_done  = req_state && (bus.mem_ack || tmo_hit);
  // Ports 0..7 are inputs (INP); the port number travels in T2 bits 5:1.
  assign io_inp    = (addr_hi_reg[5:1] < 5'd8);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  // Next-state decode.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (t2_go) begin
          case (t2_cyc)
            CYC_PCI: state_next = int_pending_reg ? S_RD_HOLD : S_RD_REQ;
            CYC_PCR: state_next = S_RD_REQ;
            CYC_PCC: state_next = S_IO;
            CYC_PCW: state_next = S_WR_DATA;
          endcase
        end
      end
      S_RD_REQ:  if (req_done) state_next = S_RD_HOLD;
      S_RD_HOLD: if (seen_t3_reg && (bus.state_in != T_T3)) state_next = S_IDLE;
      S_WR_DATA: if (bus.state_in == T_T3) state_next = S_WR_REQ;
      S_WR_REQ:  if (req_done) state_next = S_IDLE;
      S_IO:      state_next = S_RD_HOLD;
      default:   state_next = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    mem_req = 1'b0;
    mem_we  = 1'b0;
    ready   = 1'b0;
    case (state_reg)
      S_RD_REQ:  mem_req = 1'b1;
      S_WR_REQ: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
      end
      S_RD_HOLD: ready = 1'b1;
      S_WR_DATA: ready = 1'b1;
      default:   ;
    endcase
  end

  // Address/data latches, interrupt flag, timeout counter and strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_lo_reg     <= 8'h00;
      addr_lo_lat_reg <= 8'h00;
      addr_hi_reg     <= 6'h00;
      cyc_type_reg    <= 2'b00;
      int_pending_reg <= 1'b0;
      d_to_cpu_reg    <= 8'h00;
      mem_wdata_reg   <= 8'h00;
      tmo_cnt_reg     <= '0;
      bus_err_reg     <= 1'b0;
      io_strb_reg     <= 1'b0;
      seen_t3_reg     <= 1'b0;
      pend_valid_reg  <= 1'b0;
      pend_data_reg   <= 8'h00;
    end else begin
      bus_err_reg <= tmo_hit;
      io_strb_reg <= (state_reg == S_IDLE) && (state_next == S_IO);
      seen_t3_reg <= (state_reg == S_RD_HOLD) && (seen_t3_reg || (bus.state_in == T_T3));

      if ((bus.state_in == T_T1) || (bus.state_in == T_T1I))
        addr_lo_reg <= bus.d_from_cpu;

      if (bus.state_in == T_T1I)
        int_pending_reg <= 1'b1;
      else if ((state_reg == S_RD_HOLD) && (state_next == S_IDLE) && (cyc_type_reg == CYC_PCI))
        int_pending_reg <= 1'b0;

      if (req_state && !req_done) tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
      else                        tmo_cnt_reg <= '0;

      if (state_reg == S_IDLE)
        pend_valid_reg <= 1'b0;
      else if ((state_reg == S_WR_REQ) && (bus.state_in == T_T2)) begin
        pend_valid_reg <= 1'b1;
        pend_data_reg  <= bus.d_from_cpu;
      end

      if ((state_reg == S_IDLE) && t2_go) begin
        addr_hi_reg     <= t2_data[5:0];
        cyc_type_reg    <= t2_cyc;
        addr_lo_lat_reg <= addr_lo_reg;
      end

      if ((state_reg == S_IDLE) && t2_go && (t2_cyc == CYC_PCI) && int_pending_reg)
        d_to_cpu_reg <= bus.int_vector;
      else if ((state_reg == S_RD_REQ) && bus.mem_ack)
        d_to_cpu_reg <= bus.mem_rdata;
      else if ((state_reg == S_RD_REQ) && tmo_hit)
        d_to_cpu_reg <= 8'hFF;
      else if ((state_reg == S_IO) && io_inp)
        d_to_cpu_reg <= bus.io_rdata;

      if ((state_reg == S_WR_DATA) && (bus.state_in == T_T3))
        mem_wdata_reg <= bus.d_from_cpu;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_io_port
      assign io_port_w[gi] = addr_hi_reg[gi+1];
    end
  endgenerate

  assign bus.d_to_cpu     = d_to_cpu_reg;
  assign bus.ready_to_cpu = ready;
  assign bus.mem_addr     = {addr_hi_reg, addr_lo_lat_reg};
  assign bus.mem_req      = mem_req;
  assign bus.mem_we       = mem_we;
  assign bus.mem_wdata    = mem_wdata_reg;
  assign bus.io_strb      = io_strb_reg;
  assign bus.io_port      = io_port_w;
  assign bus.io_wdata     = addr_lo_lat_reg;
  assign bus.cyc_type     = cyc_type_reg;
  assign bus.bus_err      = bus_err_reg;

endmodule
